md5_padder: RTL

Byte-stream front end for the MD5 compression core. Accepts message bytes with an end-of-message marker and assembles 512-bit blocks in the core's little-endian word layout. On the final byte it inserts the 0x80 terminator, zero fill and the 64-bit bit-length, emitting an extra padding block when required. Sits between the host/byte source and the MD5 core's 16-word message inputs.

---
 rtl/md5_pkg.sv | 21 ++
 rtl/md5_block_buf.sv | 45 ++++
 rtl/md5_padder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared constants, FSM state type and byte-lane mapping for the MD5 padder.
// Little-endian lane mapping: byte i of a block lives in word i/4 at bits 8*(i%4).
package md5_pkg;

   localparam int MD5_BLOCK_BYTES = 64;
   localparam int MD5_LEN_OFFSET = 56;
   localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

   typedef enum logic [2:0] {
      FILL,
      EMIT_DATA,
      EMIT_PAD,
      PAD_BLK,
      EMIT_FINAL
   } state_e;

   function automatic int byteLane(input int idx);
      return 32 * (idx / 4) + 8 * (idx % 4);
   endfunction

endpackage

// File: rtl/md5_block_buf.sv
// 64-byte block buffer: single data-byte write, pad-byte write, full clear and
// length-field write in one cycle, packed into the core's 16-word layout.
module md5_block_buf
   import md5_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         wr_en_i,
   input  logic [5:0]   wr_idx_i,
   input  logic [7:0]   wr_byte_i,
   input  logic         pad_en_i,
   input  logic [5:0]   pad_idx_i,
   input  logic         len_en_i,
   input  logic [63:0]  len_i,
   output logic [511:0] blk_data_o
);

   logic [7:0] mem_q [MD5_BLOCK_BYTES];

   // Later writes in this block override the clear, so a block can be cleared
   // and seeded with the pad byte and length in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MD5_BLOCK_BYTES; i++) mem_q[i] <= '0;
      end else begin
         if (clr_i) begin
            for (int i = 0; i < MD5_BLOCK_BYTES; i++) mem_q[i] <= '0;
         end
         if (wr_en_i) mem_q[wr_idx_i] <= wr_byte_i;
         if (pad_en_i) mem_q[pad_idx_i] <= MD5_PAD_BYTE;
         if (len_en_i) begin
            for (int k = 0; k < 8; k++) mem_q[MD5_LEN_OFFSET + k] <= len_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      blk_data_o = '0;
      for (int i = 0; i < MD5_BLOCK_BYTES; i++) begin
         blk_data_o[byteLane(i) +: 8] = mem_q[i];
      end
   end

endmodule

// File: rtl/md5_padder.sv
// MD5 byte-stream padder: assembles 512-bit blocks and appends 0x80, zero fill
// and the 64-bit bit length. Define MD5_PADDER_LEN_OUT_EN to expose msg_bits.
module md5_padder
   import md5_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [511:0]     blk_data,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic             blk_last
`ifdef MD5_PADDER_LEN_OUT_EN
   ,
   output logic [LEN_W-1:0] msg_bits
`endif
);

   state_e             state_q, state_d;
   logic [5:0]         ptr_q, ptr_d;
   logic [LEN_W-4:0]   cnt_q, cnt_d;
   logic               padPending_q, padPending_d;
   logic               bufClr, bufWrEn, bufPadEn, bufLenEn;
   logic [5:0]         bufPadIdx;
   logic [LEN_W-1:0]   lenBits;
   logic [63:0]        len64;

   // Length always tracks the next-state byte count so the final byte is included.
   assign lenBits = {cnt_d, 3'b000};
   assign len64   = 64'(lenBits);

   assign in_ready  = (state_q == FILL) && !reset;
   assign blk_valid = (state_q == EMIT_DATA) || (state_q == EMIT_PAD) || (state_q == EMIT_FINAL);
   assign blk_last  = (state_q == EMIT_FINAL);

`ifdef MD5_PADDER_LEN_OUT_EN
   assign msg_bits = {cnt_q, 3'b000};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FILL;
         ptr_q        <= '0;
         cnt_q        <= '0;
         padPending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         padPending_q <= padPending_d;
      end
   end

   // A final byte at 55 or beyond leaves no room for the length, forcing a pad block.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      padPending_d = padPending_q;
      bufClr       = 1'b0;
      bufWrEn      = 1'b0;
      bufPadEn     = 1'b0;
      bufPadIdx    = ptr_q + 6'd1;
      bufLenEn     = 1'b0;
      case (state_q)
         FILL: begin
            if (in_valid) begin
               bufWrEn = 1'b1;
               ptr_d   = ptr_q + 6'd1;
               cnt_d   = cnt_q + (LEN_W-3)'(1);
               if (in_last) begin
                  if (ptr_q <= 6'(MD5_LEN_OFFSET - 2)) begin
                     bufPadEn = 1'b1;
                     bufLenEn = 1'b1;
                     state_d  = EMIT_FINAL;
                  end else if (ptr_q != 6'd63) begin
                     bufPadEn = 1'b1;
                     state_d  = EMIT_PAD;
                  end else begin
                     padPending_d = 1'b1;
                     state_d      = EMIT_PAD;
                  end
               end else if (ptr_q == 6'd63) begin
                  state_d = EMIT_DATA;
               end
            end
         end
         EMIT_DATA: begin
            if (blk_ready) begin
               bufClr  = 1'b1;
               ptr_d   = '0;
               state_d = FILL;
            end
         end
         EMIT_PAD: begin
            if (blk_ready) state_d = PAD_BLK;
         end
         PAD_BLK: begin
            bufClr    = 1'b1;
            bufPadEn  = padPending_q;
            bufPadIdx = '0;
            bufLenEn  = 1'b1;
            state_d   = EMIT_FINAL;
         end
         EMIT_FINAL: begin
            if (blk_ready) begin
               bufClr       = 1'b1;
               ptr_d        = '0;
               cnt_d        = '0;
               padPending_d = 1'b0;
               state_d      = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   md5_block_buf u_buf (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (bufClr),
      .wr_en_i    (bufWrEn),
      .wr_idx_i   (ptr_q),
      .wr_byte_i  (in_data),
      .pad_en_i   (bufPadEn),
      .pad_idx_i  (bufPadIdx),
      .len_en_i   (bufLenEn),
      .len_i      (len64),
      .blk_data_o (blk_data)
   );

endmodule
